port_out_uart_tx: RTL
=====================

Name: port_out_uart_tx

Overview:
- Downstream consumer of the processor's 32-bit PortOut.
- Accepts 32-bit words on a write strobe and buffers them in a small FIFO.
- Serializes each word as four UART 8N1 frames (byte 0 = bits [7:0] first, each byte LSB-first) on a single tx line.
- Lets the single-cycle-per-stage pipeline post output words without stalling on the slow serial link.

Parameters:
- BAUD_DIV, 434, clock cycles per UART bit (434 = 50 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 4, word entries in the buffer; power of two, ≥2.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; clears FIFO, FSM and counters immediately.
- wr_en  input  1  write strobe; the word is accepted on a rising clk edge when wr_en=1 and full=0.
- wr_data  input  32  word to transmit.
- full  output  1  registered; 1 when the FIFO holds FIFO_DEPTH words.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  registered number of words currently buffered.
- overflow  output  1  sticky; set when wr_en=1 while full=1; cleared only by reset.
- busy  output  1  1 whenever the FSM is not in IDLE.
- tx  output  1  serial line, idle high.

Behaviour:
- Reset (reset=0, asynchronous):
  - tx=1, busy=0, full=0, fifo_count=0, overflow=0.
  - FSM enters IDLE; FIFO pointers, bit/byte/baud counters go to 0.
  - Takes effect mid-frame immediately; no partial frame is completed.
- FIFO:
  - Circular buffer with pointers of width $clog2(FIFO_DEPTH).
  - Pointers wrap at FIFO_DEPTH-1 → 0.
  - full and fifo_count are computed from the state before the edge.
  - A write when full=1 is dropped and sets overflow, even if a pop occurs on the same edge.
  - A write and a pop on the same edge leave fifo_count unchanged.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if fifo_count≠0, pop the head word into a 32-bit shift register, set byte_idx=0, go to START. The pop happens on the IDLE→START edge.
  - START: tx=0 for BAUD_DIV cycles, then go to DATA with bit_idx=0.
  - DATA: tx = current byte bit[bit_idx] for BAUD_DIV cycles per bit. After bit 7, go to STOP.
  - STOP: tx=1 for BAUD_DIV cycles.
    - If byte_idx<3: increment byte_idx, shift the register right by 8, go to START. No idle gap between bytes.
    - If byte_idx=3: go to IDLE.
- IDLE lasts at least one clock between words.
- Latency: write into an empty FIFO at edge N → pop at edge N+1 → tx falls at edge N+2.
- Full word = 4×(10×BAUD_DIV) cycles, plus one IDLE clock before the next word.
- tx is registered; no combinational path from wr_en to tx.
- busy=1 from the IDLE→START edge until the STOP→IDLE edge.
- wr_data X while wr_en=0 has no effect.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP.
  - tx = even parity (XOR of the 8 data bits) for BAUD_DIV cycles.
  - Frame becomes 8E1 = 11 bit times; word time = 44×BAUD_DIV cycles.
- Undefined: no PARITY state, 8N1 as above. Ports and other timing are identical in both builds.

Test Plan:
- Reset/idle: hold reset=0 for 3 clk, release → tx=1, busy=0, full=0, fifo_count=0, overflow=0; tx stays 1 for 100 clk with wr_en=0.
- Single word: BAUD_DIV=4, write 32'hA5C3_0F81 → tx falls 2 clk after the write edge. Bytes 81,0F,C3,A5 are sampled LSB-first at bit centres, with a stop bit high after each. busy deasserts after exactly 160 clk from the first start bit.
- FIFO fill: BAUD_DIV=4, FIFO_DEPTH=4, write 5 words on consecutive clocks. First is popped immediately; the remaining 4 fill the FIFO, so full=1 and fifo_count=4. All 5 words are transmitted in order, with exactly 1 idle clock between words. overflow remains 0.
- Overflow: with full=1, pulse wr_en with 32'hDEAD_BEEF → word dropped (never seen on tx), overflow=1 and it stays 1 after the FIFO drains.
- Reset mid-frame: assert reset during DATA of byte 2 → tx=1 in the same cycle (asynchronous). After release, fifo_count=0 and no further start bit is seen.
- Parity build (UART_TX_PARITY_EN): send 32'h0000_0103 → parity bits are 0 (byte 03), 1 (byte 01), 0, 0; word time = 176 clk at BAUD_DIV=4.

Source files
------------

// File: rtl/port_out_uart_tx.sv
// PortOut word buffer + UART serializer: each 32-bit word goes out as four 8N1 frames, LSB byte first.
// Optional build macro UART_TX_PARITY_EN switches the frames to 8E1 (adds a PARITY bit time).
module port_out_uart_tx #(
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [31:0]                   wr_data,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          busy,
  output logic                          tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [1:0]      byte_q, byte_d;
  logic [31:0]     shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_q, full_d;
  logic            ovf_q, ovf_d;
  logic            push, pop, baud_last;
  logic [31:0]     mem_q [FIFO_DEPTH];

  // FIFO bookkeeping; a write while full is dropped even if a pop happens on the same edge
  always_comb begin
    push     = wr_en && !full_q;
    pop      = (state_q == S_IDLE) && (count_q != '0);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    full_d   = (count_d == CW'(FIFO_DEPTH));
    ovf_d    = ovf_q | (wr_en & full_q);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    shift_d   = shift_q;
    baud_last = (baud_q == 16'(BAUD_DIV - 1));
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d = mem_q[rd_ptr_q];
          byte_d  = 2'd0;
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_last) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (byte_q != 2'd3) begin
            byte_d  = byte_q + 2'd1;
            shift_d = {8'd0, shift_q[31:8]};
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // tx is a registered decode of the current state, so it trails the FSM by one clock
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[bit_q];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = ^shift_q[7:0];
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
    end
  end

  assign full       = full_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign busy       = (state_q != S_IDLE);
  assign tx         = tx_q;

endmodule
